frame_stream_generator: RTL and testbench
=========================================

// Module: frame_stream_generator
// PURPOSE
// - Parametrised Ethernet-style test-frame source: Avalon-MM 8-bit config slave in, AXI-Stream egress out.
// - Replaces the fixed 16-bit single-payload-word generator with:
//   - a byte-addressable payload buffer;
//   - configurable stream width with tkeep;
//   - frame-count limit, enable/clear control, and statistics readback.
// - Feeds the packet-filter ingress in test builds.
// PARAMETERS
// - DATA_W         16   egress width in bits; multiple of 8, 16..64; BPB = DATA_W/8 bytes per beat
// - PAYLOAD_DEPTH  256  payload buffer bytes; power of 2, <= 256
// - ADDR_W         10   Avalon address width; must reach 256+PAYLOAD_DEPTH-1
// PORTS
// - clk                 in   1          clock
// - reset               in   1          synchronous, active-high
// - writedata           in   8          Avalon write data
// - write               in   1          Avalon write strobe
// - chipselect          in   1          Avalon select
// - address             in   ADDR_W     Avalon byte address
// - read                in   1          Avalon read strobe
// - readdata            out  8          Avalon read data, registered
// - egress_port_tdata   out  DATA_W     stream data; first wire byte in bits [DATA_W-1:DATA_W-8]
// - egress_port_tkeep   out  DATA_W/8   byte valid, MSB-aligned
// - egress_port_tlast   out  1          last beat of frame
// - egress_port_tready  in   1          sink ready
// - egress_port_tvalid  out  1          beat valid
// BEHAVIOUR
// - Register map (W = write, R = read):
//   - 0-5 dst MAC; 6-11 src MAC; 12/13 length LSB/MSB; 14-15 type; 16 gap cycles; 17 frame limit (0 = continuous)   RW
//   - 18 ctrl: bit0 enable; bit1 clear_stats (self-clearing, reads 0)   RW
//   - 19 status: bit0 busy (state != IDLE); bit1 done   R
//   - 20/21 frames_sent LSB/MSB; 22-25 checksum bytes 0..3   R
//   - 256 + i: payload byte i   W/R
//   - Unmapped writes are ignored; unmapped reads return 0.
// - readdata: 1-cycle registered latency; 0 when no chipselect&&read.
// - Reset values: all regs, payload buffer, frames_sent and checksum = 0; state IDLE; all outputs 0.
// - Wire byte order: 0xAA x7, 0xAB, dst[0..5], src[0..5], len MSB, len LSB, type[14], type[15], payload[0..L-1], optional trailer.
// - L = min({reg13,reg12}, PAYLOAD_DEPTH).
// - Total bytes T = 24 + L (+4 with FCS).
// - Beats = ceil(T/BPB). On the last beat:
//   - tkeep has the top (T mod BPB, or BPB if 0) bits set;
//   - unused bytes of tdata = 0;
//   - tlast = 1.
// - Latched at IDLE->SEND: L, header regs, gap value.
// - Payload writes during SEND are allowed: bytes are read live; the byte count stays fixed.
// - FSM states:
//   - IDLE: move to SEND when enable && (limit == 0 || frames_sent < limit); otherwise stay.
//   - SEND: tvalid = 1; advance one beat on tvalid && tready. While tready = 0, tdata, tkeep and tlast are held stable.
//   - On the last-beat handshake:
//     - frames_sent++ (saturates at 0xFFFF);
//     - checksum = 32-bit sum of the frame's payload bytes;
//     - go to GAP.
//   - GAP: down-counter loaded with reg16; decrements each cycle; at 0 go to IDLE.
//   - Result: tvalid is low for exactly reg16 + 1 cycles between frames.
// - done = 1 when limit != 0 && frames_sent >= limit. A limit write or clear_stats re-evaluates it.
// - Enable cleared mid-frame: the current frame completes with tlast, then the FSM stays IDLE. No truncated frames.
// - clear_stats: zeroes frames_sent and checksum in the cycle after the write. If it coincides with a frame-end update, clear wins.
// - Reset mid-frame: tvalid = 0 from the first reset cycle; the frame is abandoned.
// - Length 0: header-only frame of 24 bytes.
// CONFIGURATION
// - FRAME_GEN_FCS_EN defined:
//   - append a 4-byte trailer after the payload = 32-bit payload byte sum, MSB first, packed contiguously with the payload;
//   - T includes 4.
// - FRAME_GEN_FCS_EN undefined: no trailer; the checksum is readback only.
// TESTING
// - DATA_W=16, payload 01 02 03 04, L=4, limit=1, gap=0, tready=1, enable:
//   - 14 beats; beats 0-2 = AAAA, beat 3 = AAAB, beat 10 = 0004;
//   - beats 12-13 = 0102, 0304; tlast on beat 13, tkeep=11;
//   - frames_sent=1, checksum=0x0000000A, done=1.
// - L=3 (payload 01 02 03): last beat = 0300, tkeep=10, 14 beats total.
// - Random tready (50%): captured beat sequence is identical to the tready=1 case; tdata stable during every stall.
// - gap=5, limit=3: exactly 6 tvalid-low cycles between frames; 3 frames sent; then idle with done=1.
// - Clear enable mid-frame: frame ends with tlast, no further tvalid. Assert reset mid-frame: tvalid=0 that cycle; all registers read 0.
// - FRAME_GEN_FCS_EN, first scenario: 16 beats; beats 14-15 = 0000, 000A; tlast on beat 15.

Source files
------------

// File: rtl/frame_stream_generator.sv
// Test-frame source: Avalon-MM byte-wide config slave, AXI-Stream egress with MSB-aligned tkeep.
// Define FRAME_GEN_FCS_EN to append the 4-byte payload-sum trailer to every frame.
module frame_stream_generator #(
  parameter int DATA_W        = 16,
  parameter int PAYLOAD_DEPTH = 256,
  parameter int ADDR_W        = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          writedata,
  input  logic                write,
  input  logic                chipselect,
  input  logic [ADDR_W-1:0]   address,
  input  logic                read,
  output logic [7:0]          readdata,
  output logic [DATA_W-1:0]   egress_port_tdata,
  output logic [DATA_W/8-1:0] egress_port_tkeep,
  output logic                egress_port_tlast,
  input  logic                egress_port_tready,
  output logic                egress_port_tvalid
);

  localparam int BPB = DATA_W / 8;
  localparam int PW  = (PAYLOAD_DEPTH > 1) ? $clog2(PAYLOAD_DEPTH) : 1;
`ifdef FRAME_GEN_FCS_EN
  localparam logic [15:0] TRAILER = 16'd4;
`else
  localparam logic [15:0] TRAILER = 16'd0;
`endif

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t             state;
  logic [7:0]         cfg [0:17];
  logic               enable;
  logic [7:0]         payload [0:PAYLOAD_DEPTH-1];
  logic [15:0]        frames_sent;
  logic [31:0]        checksum;
  logic [7:0]         hdr [0:15];
  logic [15:0]        len_q;
  logic [7:0]         gap_q;
  logic [7:0]         gap_cnt;
  logic [15:0]        next_pos;
  logic [31:0]        run_sum;
  logic [DATA_W-1:0]  tdata_q;
  logic [BPB-1:0]     tkeep_q;
  logic               tlast_q;
  logic               tvalid_q;

  logic               wr_en, rd_en, payload_hit, clear_req, done, can_start, handshake;
  logic [15:0]        cfg_len, len_eff, total;
  logic [7:0]         rd_val;

  assign wr_en       = chipselect && write;
  assign rd_en       = chipselect && read;
  assign payload_hit = (address >= ADDR_W'(256)) && (address < ADDR_W'(256 + PAYLOAD_DEPTH));
  assign clear_req   = wr_en && (address == ADDR_W'(18)) && writedata[1];
  assign cfg_len     = {cfg[13], cfg[12]};
  assign len_eff     = (cfg_len > 16'(PAYLOAD_DEPTH)) ? 16'(PAYLOAD_DEPTH) : cfg_len;
  assign total       = 16'd24 + len_q + TRAILER;
  assign done        = (cfg[17] != 8'd0) && (frames_sent >= {8'd0, cfg[17]});
  assign can_start   = enable && ((cfg[17] == 8'd0) || (frames_sent < {8'd0, cfg[17]}));
  assign handshake   = tvalid_q && egress_port_tready;

  // Reset pulls tvalid low immediately so an abandoned frame never shows another beat.
  assign egress_port_tvalid = tvalid_q && !reset;
  assign egress_port_tdata  = tdata_q;
  assign egress_port_tkeep  = tkeep_q;
  assign egress_port_tlast  = tlast_q;

  always_comb begin
    rd_val = 8'h00;
    if (address < ADDR_W'(18))       rd_val = cfg[address[4:0]];
    else if (address == ADDR_W'(18)) rd_val = {7'd0, enable};
    else if (address == ADDR_W'(19)) rd_val = {6'd0, done, state != IDLE};
    else if (address == ADDR_W'(20)) rd_val = frames_sent[7:0];
    else if (address == ADDR_W'(21)) rd_val = frames_sent[15:8];
    else if (address == ADDR_W'(22)) rd_val = checksum[7:0];
    else if (address == ADDR_W'(23)) rd_val = checksum[15:8];
    else if (address == ADDR_W'(24)) rd_val = checksum[23:16];
    else if (address == ADDR_W'(25)) rd_val = checksum[31:24];
    else if (payload_hit)            rd_val = payload[address[PW-1:0]];
  end

  // Next-beat builder: assembles BPB wire bytes from build_pos and folds payload bytes into the running sum.
  logic [15:0]       build_pos, idx, hidx, pidx, fidx;
  logic [7:0]        byte_v;
  logic [31:0]       acc;
  logic [DATA_W-1:0] b_data;
  logic [BPB-1:0]    b_keep;
  logic              b_last;

  always_comb begin
    build_pos = (state == SEND) ? next_pos : 16'd0;
    acc       = (state == SEND) ? run_sum : 32'd0;
    b_data    = '0;
    b_keep    = '0;
    b_last    = (build_pos + 16'(BPB)) >= total;
    idx       = 16'd0;
    hidx      = 16'd0;
    pidx      = 16'd0;
    fidx      = 16'd0;
    byte_v    = 8'h00;
    for (int k = 0; k < BPB; k++) begin
      idx    = build_pos + 16'(k);
      hidx   = idx - 16'd8;
      pidx   = idx - 16'd24;
      fidx   = idx - 16'd24 - len_q;
      byte_v = 8'h00;
      if (idx < total) begin
        b_keep[BPB-1-k] = 1'b1;
        if (idx < 16'd7)                byte_v = 8'hAA;
        else if (idx == 16'd7)          byte_v = 8'hAB;
        else if (idx == 16'd20)         byte_v = hdr[13];
        else if (idx == 16'd21)         byte_v = hdr[12];
        else if (idx < 16'd24)          byte_v = hdr[hidx[3:0]];
        else if (idx < 16'd24 + len_q) begin
          byte_v = payload[pidx[PW-1:0]];
          acc    = acc + {24'd0, byte_v};
        end
`ifdef FRAME_GEN_FCS_EN
        else begin
          case (fidx[1:0])
            2'd0:    byte_v = acc[31:24];
            2'd1:    byte_v = acc[23:16];
            2'd2:    byte_v = acc[15:8];
            default: byte_v = acc[7:0];
          endcase
        end
`endif
      end
      b_data[DATA_W-1-8*k -: 8] = byte_v;
    end
  end

  // Config/payload writes, registered readback and the IDLE/SEND/GAP sequencer; clear_stats overrides a frame-end update.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 18; i++) cfg[i] <= 8'h00;
      for (int i = 0; i < 16; i++) hdr[i] <= 8'h00;
      for (int i = 0; i < PAYLOAD_DEPTH; i++) payload[i] <= 8'h00;
      enable      <= 1'b0;
      frames_sent <= 16'd0;
      checksum    <= 32'd0;
      state       <= IDLE;
      len_q       <= 16'd0;
      gap_q       <= 8'd0;
      gap_cnt     <= 8'd0;
      next_pos    <= 16'd0;
      run_sum     <= 32'd0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tlast_q     <= 1'b0;
      tvalid_q    <= 1'b0;
      readdata    <= 8'h00;
    end else begin
      readdata <= rd_en ? rd_val : 8'h00;
      if (wr_en) begin
        if (address < ADDR_W'(18))       cfg[address[4:0]] <= writedata;
        else if (address == ADDR_W'(18)) enable <= writedata[0];
        else if (payload_hit)            payload[address[PW-1:0]] <= writedata;
      end

      case (state)
        IDLE: begin
          if (can_start) begin
            for (int i = 0; i < 16; i++) hdr[i] <= cfg[i];
            len_q    <= len_eff;
            gap_q    <= cfg[16];
            state    <= SEND;
            tvalid_q <= 1'b1;
            tdata_q  <= b_data;
            tkeep_q  <= b_keep;
            tlast_q  <= b_last;
            run_sum  <= acc;
            next_pos <= 16'(BPB);
          end
        end
        SEND: begin
          if (handshake) begin
            if (tlast_q) begin
              if (frames_sent != 16'hFFFF) frames_sent <= frames_sent + 16'd1;
              checksum <= run_sum;
              tvalid_q <= 1'b0;
              tdata_q  <= '0;
              tkeep_q  <= '0;
              tlast_q  <= 1'b0;
              gap_cnt  <= gap_q;
              state    <= (gap_q == 8'd0) ? IDLE : GAP;
            end else begin
              tdata_q  <= b_data;
              tkeep_q  <= b_keep;
              tlast_q  <= b_last;
              run_sum  <= acc;
              next_pos <= next_pos + 16'(BPB);
            end
          end
        end
        GAP: begin
          // The IDLE cycle that follows supplies the final low cycle of the gap.
          gap_cnt <= gap_cnt - 8'd1;
          if (gap_cnt <= 8'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (clear_req) begin
        frames_sent <= 16'd0;
        checksum    <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_frame_stream_generator.sv
// Directed bench for frame_stream_generator (DATA_W=16): register vector table plus hand-built frame sequences.
module tb_frame_stream_generator;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        writedata = 8'h00;
  logic              write = 1'b0;
  logic              chipselect = 1'b0;
  logic [ADDR_W-1:0] address = '0;
  logic              read = 1'b0;
  logic [7:0]        readdata;
  logic [DATA_W-1:0] egress_port_tdata;
  logic [1:0]        egress_port_tkeep;
  logic              egress_port_tlast;
  logic              egress_port_tready = 1'b1;
  logic              egress_port_tvalid;

  frame_stream_generator #(.DATA_W(DATA_W), .PAYLOAD_DEPTH(256), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .writedata(writedata), .write(write),
    .chipselect(chipselect), .address(address), .read(read), .readdata(readdata),
    .egress_port_tdata(egress_port_tdata), .egress_port_tkeep(egress_port_tkeep),
    .egress_port_tlast(egress_port_tlast), .egress_port_tready(egress_port_tready),
    .egress_port_tvalid(egress_port_tvalid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  keep;
    logic        last;
  } beat_t;

  typedef struct {
    logic       wr;
    logic [9:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  int    vectors = 0;
  int    miscompares = 0;
  beat_t cap[$];
  int    gaps[$];
  int    stall_err = 0;
  logic  rand_ready = 1'b0;

  // Ready driver: random 50% when requested, otherwise always ready.
  always @(negedge clk) egress_port_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;

  // Beat monitor: captures handshakes, checks stall stability, and measures tvalid-low runs after each tlast.
  logic  held = 1'b0;
  beat_t held_beat;
  beat_t cur;
  logic  after_last = 1'b0;
  int    low_cnt = 0;
  always @(negedge clk) begin
    #1;
    cur = {egress_port_tdata, egress_port_tkeep, egress_port_tlast};
    if (reset) begin
      held = 1'b0;
      after_last = 1'b0;
    end else if (egress_port_tvalid) begin
      if (held && cur != held_beat) stall_err++;
      if (after_last) begin
        gaps.push_back(low_cnt);
        after_last = 1'b0;
      end
      if (egress_port_tready) begin
        cap.push_back(cur);
        held = 1'b0;
        if (cur.last) begin
          after_last = 1'b1;
          low_cnt = 0;
        end
      end else begin
        held = 1'b1;
        held_beat = cur;
      end
    end else begin
      if (held) stall_err++;
      held = 1'b0;
      if (after_last) low_cnt++;
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic av_write(input logic [9:0] a, input logic [7:0] d);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic av_read(input logic [9:0] a, output logic [7:0] d);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(negedge clk);
    d = readdata;
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic check_reg(input string name, input logic [9:0] a, input logic [7:0] exp);
    logic [7:0] d;
    av_read(a, d);
    check_output(name, {24'd0, d}, {24'd0, exp});
  endtask

  task automatic apply_stimulus(input vec_t v, input int n);
    if (v.wr) av_write(v.addr, v.wdata);
    check_reg($sformatf("reg vector %0d addr %0d", n, v.addr), v.addr, v.exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_beats(input string name, input int target, input int budget);
    int n = 0;
    while (cap.size() < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_output({name, " beats arrived in time"}, {31'd0, cap.size() >= target}, 32'd1);
  endtask

  task automatic compare_frame(input string name, input int base, input beat_t exp[$]);
    int got = cap.size() - base;
    check_output({name, " beat count"}, got, exp.size());
    for (int i = 0; i < exp.size() && i < got; i++) begin
      check_output($sformatf("%s beat %0d tdata", name, i), {16'd0, cap[base+i].data}, {16'd0, exp[i].data});
      check_output($sformatf("%s beat %0d tkeep", name, i), {30'd0, cap[base+i].keep}, {30'd0, exp[i].keep});
      check_output($sformatf("%s beat %0d tlast", name, i), {31'd0, cap[base+i].last}, {31'd0, exp[i].last});
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t        vt[$];
    logic [15:0] w1[14];
    logic [9:0]  zero_addr[11];
    beat_t       exp1[$];
    beat_t       exp3[$];
    int          base, gb, n1;

    w1 = '{16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAB, 16'h1112, 16'h1314, 16'h1516,
           16'h2122, 16'h2324, 16'h2526, 16'h0004, 16'h0800, 16'h0102, 16'h0304};
    for (int i = 0; i < 14; i++) exp1.push_back('{w1[i], 2'b11, 1'b0});
`ifdef FRAME_GEN_FCS_EN
    exp1.push_back('{16'h0000, 2'b11, 1'b0});
    exp1.push_back('{16'h000A, 2'b11, 1'b0});
`endif
    exp1[exp1.size()-1].last = 1'b1;
    n1 = exp1.size();

    for (int i = 0; i < 12; i++) exp3.push_back('{w1[i], 2'b11, 1'b0});
    exp3[10].data = 16'h0003;
    exp3.push_back('{16'h0102, 2'b11, 1'b0});
`ifdef FRAME_GEN_FCS_EN
    exp3.push_back('{16'h0300, 2'b11, 1'b0});
    exp3.push_back('{16'h0000, 2'b11, 1'b0});
    exp3.push_back('{16'h0600, 2'b10, 1'b1});
`else
    exp3.push_back('{16'h0300, 2'b10, 1'b1});
`endif

    vt.push_back('{1'b0, 10'd0,   8'h00, 8'h00});
    vt.push_back('{1'b0, 10'd18,  8'h00, 8'h00});
    vt.push_back('{1'b0, 10'd19,  8'h00, 8'h00});
    vt.push_back('{1'b0, 10'd20,  8'h00, 8'h00});
    vt.push_back('{1'b0, 10'd22,  8'h00, 8'h00});
    vt.push_back('{1'b1, 10'd5,   8'h5A, 8'h5A});
    vt.push_back('{1'b1, 10'd300, 8'h77, 8'h77});
    vt.push_back('{1'b1, 10'd18,  8'h02, 8'h00});
    vt.push_back('{1'b1, 10'd30,  8'h55, 8'h00});
    vt.push_back('{1'b1, 10'd17,  8'h03, 8'h03});
    vt.push_back('{1'b1, 10'd511, 8'h9C, 8'h9C});
    vt.push_back('{1'b1, 10'd16,  8'h07, 8'h07});

    // Reset state of the stream outputs and readback.
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check_output("reset tvalid", {31'd0, egress_port_tvalid}, 32'd0);
    check_output("reset tdata", {16'd0, egress_port_tdata}, 32'd0);
    check_output("reset tkeep", {30'd0, egress_port_tkeep}, 32'd0);
    check_output("reset tlast", {31'd0, egress_port_tlast}, 32'd0);
    check_output("reset readdata", {24'd0, readdata}, 32'd0);

    for (int i = 0; i < vt.size(); i++) apply_stimulus(vt[i], i);
    @(negedge clk);
    check_output("readdata idle is zero", {24'd0, readdata}, 32'd0);
    do_reset();

    // Scenario 1: L=4, limit=1, gap=0.
    for (int i = 0; i < 6; i++) av_write(10'(i), 8'(8'h11 + i));
    for (int i = 0; i < 6; i++) av_write(10'(6 + i), 8'(8'h21 + i));
    av_write(10'd12, 8'h04); av_write(10'd13, 8'h00);
    av_write(10'd14, 8'h08); av_write(10'd15, 8'h00);
    av_write(10'd16, 8'h00); av_write(10'd17, 8'h01);
    for (int i = 0; i < 4; i++) av_write(10'(256 + i), 8'(i + 1));
    base = cap.size();
    av_write(10'd18, 8'h01);
    wait_beats("frame L4", base + n1, 200);
    repeat (10) @(negedge clk);
    compare_frame("frame L4", base, exp1);
    check_reg("frames_sent lsb", 10'd20, 8'h01);
    check_reg("frames_sent msb", 10'd21, 8'h00);
    check_reg("checksum byte0", 10'd22, 8'h0A);
    check_reg("checksum byte1", 10'd23, 8'h00);
    check_reg("status done", 10'd19, 8'h02);

    // Scenario 2: L=3 gives a half-filled last beat.
    av_write(10'd18, 8'h00);
    av_write(10'd12, 8'h03);
    base = cap.size();
    av_write(10'd18, 8'h03);
    wait_beats("frame L3", base + exp3.size(), 200);
    repeat (10) @(negedge clk);
    compare_frame("frame L3", base, exp3);
    check_reg("checksum L3", 10'd22, 8'h06);

    // Scenario 3: random backpressure must not alter the beat sequence.
    av_write(10'd18, 8'h00);
    av_write(10'd12, 8'h04);
    base = cap.size();
    rand_ready = 1'b1;
    av_write(10'd18, 8'h03);
    wait_beats("frame stalled", base + n1, 400);
    rand_ready = 1'b0;
    repeat (10) @(negedge clk);
    compare_frame("frame stalled", base, exp1);
    check_output("stall stability errors", stall_err, 32'd0);

    // Scenario 4: gap=5, limit=3 -> 6 idle cycles between frames, then done.
    av_write(10'd18, 8'h00);
    av_write(10'd16, 8'h05);
    av_write(10'd17, 8'h03);
    base = cap.size();
    gb = gaps.size();
    av_write(10'd18, 8'h03);
    wait_beats("gap frames", base + 3 * n1, 600);
    repeat (40) @(negedge clk);
    check_output("gap frames total beats", cap.size() - base, 3 * n1);
    compare_frame("gap frame 3", base + 2 * n1, exp1);
    check_output("gap entries", gaps.size() - gb, 32'd3);
    if (gaps.size() >= 2) begin
      check_output("gap 1-2 low cycles", gaps[gaps.size()-2], 32'd6);
      check_output("gap 2-3 low cycles", gaps[gaps.size()-1], 32'd6);
    end
    check_reg("frames_sent after limit", 10'd20, 8'h03);
    check_reg("status done after limit", 10'd19, 8'h02);

    // Scenario 5: enable dropped mid-frame still completes the frame.
    av_write(10'd18, 8'h00);
    av_write(10'd16, 8'h00);
    av_write(10'd17, 8'h00);
    base = cap.size();
    av_write(10'd18, 8'h01);
    wait_beats("disable midframe", base + 5, 100);
    av_write(10'd18, 8'h00);
    repeat (60) @(negedge clk);
    check_output("disable midframe beat count", cap.size() - base, n1);
    check_output("disable midframe tlast", {31'd0, cap[cap.size()-1].last}, 32'd1);
    #1;
    check_output("disable midframe tvalid idle", {31'd0, egress_port_tvalid}, 32'd0);

    // Scenario 6: reset mid-frame drops tvalid at once and clears every register.
    base = cap.size();
    av_write(10'd18, 8'h01);
    wait_beats("reset midframe", base + 3, 100);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_output("tvalid in first reset cycle", {31'd0, egress_port_tvalid}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    zero_addr = '{10'd0, 10'd5, 10'd12, 10'd16, 10'd17, 10'd18, 10'd19, 10'd20, 10'd22, 10'd256, 10'd259};
    for (int i = 0; i < 11; i++) check_reg($sformatf("post-reset addr %0d", zero_addr[i]), zero_addr[i], 8'h00);
    #1;
    check_output("post-reset tvalid", {31'd0, egress_port_tvalid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
